// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - result offer / register-file write bundle for writeback_stage
//
// Purpose: groups the even/odd pipe result offers, the flush request and the
// register-file write ports of the writeback stage into one bundle.
// master : execution side (drives offers and flush, observes writes)
// slave  : writeback stage (consumes offers, drives writes and status)
// Signals:
//   even_*/odd_* valid, rt_addr, result, lat  result offers per pipe
//   flush                                     kill in-flight results
//   rt_addr_*, rt_*, reg_write_*              register-file write ports
//   pending_mask                              registers with a staged write
//   collision_*, lat_err, waw_conflict        status
interface writeback_stage_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7
);
  logic                     even_valid;
  logic [ADDR_W-1:0]        even_rt_addr;
  logic [DATA_W-1:0]        even_result;
  logic [2:0]               even_lat;
  logic                     odd_valid;
  logic [ADDR_W-1:0]        odd_rt_addr;
  logic [DATA_W-1:0]        odd_result;
  logic [2:0]               odd_lat;
  logic                     flush;

  logic [ADDR_W-1:0]        rt_addr_even;
  logic [DATA_W-1:0]        rt_even;
  logic                     reg_write_even;
  logic [ADDR_W-1:0]        rt_addr_odd;
  logic [DATA_W-1:0]        rt_odd;
  logic                     reg_write_odd;
  logic [(1<<ADDR_W)-1:0]   pending_mask;
  logic                     collision_even;
  logic                     collision_odd;
  logic                     lat_err;
  logic                     waw_conflict;

  modport master (
    output even_valid, even_rt_addr, even_result, even_lat,
    output odd_valid, odd_rt_addr, odd_result, odd_lat,
    output flush,
    input  rt_addr_even, rt_even, reg_write_even,
    input  rt_addr_odd, rt_odd, reg_write_odd,
    input  pending_mask, collision_even, collision_odd, lat_err, waw_conflict
  );

  modport slave (
    input  even_valid, even_rt_addr, even_result, even_lat,
    input  odd_valid, odd_rt_addr, odd_result, odd_lat,
    input  flush,
    output rt_addr_even, rt_even, reg_write_even,
    output rt_addr_odd, rt_odd, reg_write_odd,
    output pending_mask, collision_even, collision_odd, lat_err, waw_conflict
  );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - dual-pipe latency-aligned result writeback stage
//
// Purpose: each pipe (0 = even, 1 = odd) owns a MAX_LAT-deep staging shift
// array. A result offered with latency L is placed in slot L-1 and shifts one
// slot per clock toward slot 0. Slot 0 is the register-file write register,
// so the write is seen L cycles after the offer.
// Ports:
//   clk    clock, all state on posedge
//   reset  synchronous, active-high; wins over flush and offers
//   wb     writeback_stage_if slave modport (offers in, writes/status out)
module writeback_stage #(
  parameter int MAX_LAT = 7,
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 7
) (
  input logic              clk,
  input logic              reset,
  writeback_stage_if.slave wb
);
  localparam int         NREG      = 1 << ADDR_W;
  localparam logic [3:0] MAX_LAT_W = 4'(MAX_LAT);

  // Staging slots, [pipe][slot]
  logic              r_vld  [2][MAX_LAT];
  logic [ADDR_W-1:0] r_addr [2][MAX_LAT];
  logic [DATA_W-1:0] r_data [2][MAX_LAT];
  logic              r_coll [2];
  logic              r_lat_err;

  logic              w_valid  [2];
  logic [ADDR_W-1:0] w_addr   [2];
  logic [DATA_W-1:0] w_data   [2];
  logic [2:0]        w_lat    [2];
  logic              w_legal  [2];
  logic [2:0]        w_idx    [2];
  logic              w_occ    [2];
  logic              w_accept [2];
  logic              w_coll   [2];
  logic [NREG-1:0]   w_pend;

  assign w_valid[0] = wb.even_valid;
  assign w_addr[0]  = wb.even_rt_addr;
  assign w_data[0]  = wb.even_result;
  assign w_lat[0]   = wb.even_lat;
  assign w_valid[1] = wb.odd_valid;
  assign w_addr[1]  = wb.odd_rt_addr;
  assign w_data[1]  = wb.odd_result;
  assign w_lat[1]   = wb.odd_lat;

  // Slot L-1 is occupied after this edge if slot L holds a valid entry now
  // (it shifts down). Slot MAX_LAT-1 is always free since nothing feeds it.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_legal[p] = (w_lat[p] != 3'd0) && ({1'b0, w_lat[p]} <= MAX_LAT_W);
      w_idx[p]   = w_lat[p] - 3'd1;
      w_occ[p]   = 1'b0;
      for (int i = 0; i < MAX_LAT - 1; i++) begin
        if (w_idx[p] == 3'(i)) w_occ[p] = r_vld[p][i+1];
      end
      w_accept[p] = w_valid[p] && w_legal[p] && !wb.flush && !w_occ[p];
      w_coll[p]   = w_valid[p] && w_legal[p] && !wb.flush && w_occ[p];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < MAX_LAT; i++) begin
          r_vld[p][i]  <= 1'b0;
          r_addr[p][i] <= '0;
          r_data[p][i] <= '0;
        end
        r_coll[p] <= 1'b0;
      end
      r_lat_err <= 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        // Flush kills everything that does not reach slot 0 at this edge;
        // the entry moving from slot 1 into slot 0 still retires.
        for (int i = 0; i < MAX_LAT - 1; i++) begin
          r_vld[p][i]  <= r_vld[p][i+1] && !(wb.flush && (i != 0));
          r_addr[p][i] <= r_addr[p][i+1];
          r_data[p][i] <= r_data[p][i+1];
        end
        r_vld[p][MAX_LAT-1] <= 1'b0;
        // A new entry overrides the shift into its target slot.
        for (int i = 0; i < MAX_LAT; i++) begin
          if (w_accept[p] && (w_idx[p] == 3'(i))) begin
            r_vld[p][i]  <= 1'b1;
            r_addr[p][i] <= w_addr[p];
            r_data[p][i] <= w_data[p];
          end
        end
        r_coll[p] <= w_coll[p];
      end
      r_lat_err <= !wb.flush &&
                   ((w_valid[0] && !w_legal[0]) || (w_valid[1] && !w_legal[1]));
    end
  end

  // Slot 0 doubles as the write register, so it is covered here as well.
  always_comb begin
    w_pend = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < MAX_LAT; i++) begin
        if (r_vld[p][i]) w_pend[r_addr[p][i]] = 1'b1;
      end
    end
  end

  assign wb.rt_addr_even   = r_addr[0][0];
  assign wb.rt_even        = r_data[0][0];
  assign wb.reg_write_even = r_vld[0][0];
  assign wb.rt_addr_odd    = r_addr[1][0];
  assign wb.rt_odd         = r_data[1][0];
  assign wb.reg_write_odd  = r_vld[1][0];
  assign wb.pending_mask   = w_pend;
  assign wb.collision_even = r_coll[0];
  assign wb.collision_odd  = r_coll[1];
  assign wb.lat_err        = r_lat_err;
  assign wb.waw_conflict   = r_vld[0][0] && r_vld[1][0] && (r_addr[0][0] == r_addr[1][0]);
endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage
module tb_writeback_stage;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  writeback_stage_if #(.DATA_W(128), .ADDR_W(7)) wb ();

  writeback_stage #(.MAX_LAT(7), .DATA_W(128), .ADDR_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    wb.even_valid = 1'b0; wb.even_rt_addr = '0; wb.even_result = '0; wb.even_lat = 3'd0;
    wb.odd_valid  = 1'b0; wb.odd_rt_addr  = '0; wb.odd_result  = '0; wb.odd_lat  = 3'd0;
    wb.flush = 1'b0;
  endtask

  task automatic offer_even(input logic [6:0] a, input logic [127:0] d, input logic [2:0] l);
    wb.even_valid = 1'b1; wb.even_rt_addr = a; wb.even_result = d; wb.even_lat = l;
  endtask

  task automatic offer_odd(input logic [6:0] a, input logic [127:0] d, input logic [2:0] l);
    wb.odd_valid = 1'b1; wb.odd_rt_addr = a; wb.odd_result = d; wb.odd_lat = l;
  endtask

  initial begin
    logic [127:0] d_a5;
    logic [127:0] d_3c;
    bit seen;
    n_vec  = 0;
    n_miss = 0;
    d_a5 = {16{8'hA5}};
    d_3c = {16{8'h3C}};
    clr_in();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;

    // Reset state
    check_vec("rst_we_even", wb.reg_write_even, 0);
    check_vec("rst_we_odd", wb.reg_write_odd, 0);
    check_vec("rst_rt_even", wb.rt_even, 0);
    check_vec("rst_pending", wb.pending_mask, 0);
    check_vec("rst_lat_err", wb.lat_err, 0);
    check_vec("rst_coll", {wb.collision_even, wb.collision_odd}, 0);

    // Basic lat=2: offer in cycle t, pending t+1..t+2, write in t+2 only
    offer_even(7'd5, d_a5, 3'd2);
    step(); clr_in();
    check_vec("l2_we_t1", wb.reg_write_even, 0);
    check_vec("l2_pend_t1", wb.pending_mask[5], 1);
    step();
    check_vec("l2_we_t2", wb.reg_write_even, 1);
    check_vec("l2_addr_t2", wb.rt_addr_even, 5);
    check_vec("l2_data_t2", wb.rt_even, d_a5);
    check_vec("l2_pend_t2", wb.pending_mask[5], 1);
    step();
    check_vec("l2_we_t3", wb.reg_write_even, 0);
    check_vec("l2_pend_t3", wb.pending_mask, 0);

    // Collision: lat4 addr3 in cycle 0, lat3 addr9 in cycle 1
    offer_even(7'd3, 128'h3, 3'd4);
    step();
    offer_even(7'd9, 128'h9, 3'd3);
    check_vec("col_c1", wb.collision_even, 0);
    step(); clr_in();
    check_vec("col_c2", wb.collision_even, 1);
    check_vec("col_odd_c2", wb.collision_odd, 0);
    check_vec("col_pend9_c2", wb.pending_mask[9], 0);
    step();
    check_vec("col_c3", wb.collision_even, 0);
    check_vec("col_we_c3", wb.reg_write_even, 0);
    step();
    check_vec("col_we_c4", wb.reg_write_even, 1);
    check_vec("col_addr_c4", wb.rt_addr_even, 3);
    check_vec("col_data_c4", wb.rt_even, 128'h3);
    step();
    check_vec("col_we_c5", wb.reg_write_even, 0);
    check_vec("col_pend_c5", wb.pending_mask, 0);

    // WAW: both pipes addr 7 lat 2
    offer_even(7'd7, d_a5, 3'd2);
    offer_odd(7'd7, d_3c, 3'd2);
    step(); clr_in();
    check_vec("waw_t1", wb.waw_conflict, 0);
    step();
    check_vec("waw_we", {wb.reg_write_even, wb.reg_write_odd}, 2'b11);
    check_vec("waw_t2", wb.waw_conflict, 1);
    check_vec("waw_rt_odd", wb.rt_odd, d_3c);
    check_vec("waw_rt_even", wb.rt_even, d_a5);
    step();
    check_vec("waw_t3", wb.waw_conflict, 0);

    // Different addresses on both pipes: no WAW
    offer_even(7'd20, d_a5, 3'd1);
    offer_odd(7'd21, d_3c, 3'd1);
    step(); clr_in();
    check_vec("nowaw_we", {wb.reg_write_even, wb.reg_write_odd}, 2'b11);
    check_vec("nowaw", wb.waw_conflict, 0);
    check_vec("nowaw_pend", wb.pending_mask, (128'b1 << 20) | (128'b1 << 21));
    step();

    // Flush: odd addr2 lat6, then addr1 lat1; flush in the cycle addr1 writes
    offer_odd(7'd2, 128'h2, 3'd6);
    step();
    offer_odd(7'd1, 128'h1, 3'd1);
    step(); clr_in();
    check_vec("fl_we1", wb.reg_write_odd, 1);
    check_vec("fl_addr1", wb.rt_addr_odd, 1);
    wb.flush = 1'b1;
    offer_even(7'd40, 128'h40, 3'd3);
    offer_odd(7'd41, 128'h41, 3'd0);
    step(); clr_in();
    check_vec("fl_lat_err", wb.lat_err, 0);
    check_vec("fl_coll", {wb.collision_even, wb.collision_odd}, 0);
    check_vec("fl_pend", wb.pending_mask, 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (wb.reg_write_odd || wb.reg_write_even) seen = 1;
      step();
    end
    check_vec("fl_no_write", seen, 0);

    // Flush while an entry is in slot 1: it still retires the next cycle
    offer_even(7'd11, 128'h11, 3'd2);
    step(); clr_in();
    wb.flush = 1'b1;
    step(); clr_in();
    check_vec("fl_s0_we", wb.reg_write_even, 1);
    check_vec("fl_s0_addr", wb.rt_addr_even, 11);
    step();

    // lat=0 rejected with lat_err; lat=7 writes 7 cycles later
    offer_even(7'd4, 128'h4, 3'd0);
    step(); clr_in();
    check_vec("l0_err", wb.lat_err, 1);
    check_vec("l0_pend", wb.pending_mask, 0);
    offer_even(7'd6, 128'h6, 3'd7);
    seen = 0;
    step(); clr_in();
    check_vec("l0_err_clr", wb.lat_err, 0);
    for (int k = 2; k < 7; k++) begin
      if (wb.reg_write_even) seen = 1;
      step();
    end
    check_vec("l7_early", seen, 0);
    step();
    check_vec("l7_we", wb.reg_write_even, 1);
    check_vec("l7_addr", wb.rt_addr_even, 6);
    step();
    check_vec("l7_done", wb.reg_write_even, 0);

    // Odd-pipe illegal latency also flags lat_err
    offer_odd(7'd8, 128'h8, 3'd0);
    step(); clr_in();
    check_vec("l0_err_odd", wb.lat_err, 1);
    check_vec("l0_we_odd", wb.reg_write_odd, 0);
    step();

    // Fill all 7 even slots, then reset
    for (int k = 0; k < 7; k++) begin
      offer_even(7'(10 + k), 128'(k + 1), 3'd7);
      step();
    end
    clr_in();
    check_vec("fill_cnt", 32'($countones(wb.pending_mask)), 7);
    check_vec("fill_we", wb.reg_write_even, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_vec("frst_we", wb.reg_write_even, 0);
    check_vec("frst_addr", wb.rt_addr_even, 0);
    check_vec("frst_data", wb.rt_even, 0);
    check_vec("frst_pend", wb.pending_mask, 0);
    seen = 0;
    for (int k = 0; k < 9; k++) begin
      if (wb.reg_write_even || wb.pending_mask != 0) seen = 1;
      step();
    end
    check_vec("frst_quiet", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Result-collection and writeback stage for the dual-issue SPU pipeline.
- Accepts results from the even and odd execution pipes, each tagged with its unit latency.
- Holds each result in a per-pipe staging shift array until that latency has elapsed.
- Then drives the register file write port for that pipe (rt_addr_*, rt_*, reg_write_*).
- Also exports a pending-destination mask for issue-side hazard checking.

Parameters:
- MAX_LAT, 7, number of staging slots per pipe; legal latency range is 1..MAX_LAT.
- DATA_W, 128, result width.
- ADDR_W, 7, register address width (128 registers).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- even_valid  input  1  even pipe presents a result this cycle.
- even_rt_addr  input  ADDR_W  destination register of the even result.
- even_result  input  DATA_W  even result value.
- even_lat  input  3  even result latency in cycles (1..MAX_LAT).
- odd_valid, odd_rt_addr, odd_result, odd_lat  input  1/ADDR_W/DATA_W/3  same fields for the odd pipe.
- flush  input  1  kill all in-flight results not yet in slot 0.
- rt_addr_even  output  ADDR_W  register file write address, even pipe.
- rt_even  output  DATA_W  register file write data, even pipe.
- reg_write_even  output  1  register file write enable, even pipe.
- rt_addr_odd, rt_odd, reg_write_odd  output  ADDR_W/DATA_W/1  same for the odd pipe.
- pending_mask  output  128  bit r set while any valid staged entry targets register r.
- collision_even, collision_odd  output  1  one-cycle pulse: the offered result was dropped because its slot was occupied.
- lat_err  output  1  one-cycle pulse: illegal latency (0 or >MAX_LAT) offered on either pipe.
- waw_conflict  output  1  high when both write enables are high with equal addresses.

Behaviour:
- Per pipe, slots 0..MAX_LAT-1 each hold {valid, addr, data}.
- Each posedge, in this order:
  - Output registers load slot 0: reg_write = slot0.valid, and addr/data are copied.
  - Slot i loads slot i+1 (i = 0..MAX_LAT-2); slot MAX_LAT-1 loads invalid.
  - If valid is high and lat is legal, the new entry is written into slot lat-1, overriding the shift.
- Timing: a result offered in cycle t with latency L shows reg_write high in cycle t+L for exactly one cycle.
- Collision: if the entry shifting into slot lat-1 is valid, the older entry is kept and the new one is dropped; collision_* is high in cycle t+1.
- Illegal latency: the result is dropped and lat_err is high in cycle t+1. No slot changes beyond the normal shift.
- Even and odd pipes are fully independent. Simultaneous offers never interact.
- waw_conflict is combinational from the output registers. Both writes still assert; the register file resolves the order.
- pending_mask is combinational: the OR of decoded addresses of all valid slots on both pipes, plus the output registers while reg_write is high.
- flush in cycle t:
  - Slots 1..MAX_LAT-1 are cleared at the edge.
  - Same-cycle offers are ignored: no collision, no lat_err.
  - Slot 0 still retires normally in cycle t+1.
- Reset in cycle t: at the edge all slots are invalidated and all outputs go to 0 (reg_write_*=0, addr/data=0, pulses=0). In-flight results are discarded.
- reset has priority over flush and over new offers.
- No backpressure: the register file always accepts a write.

Test Plan:
- Even offer addr=5, data=0xA5..A5, lat=2 in cycle 10 -> reg_write_even=1, rt_addr_even=5, rt_even=0xA5..A5 in cycle 12 only; pending_mask[5]=1 in cycles 11-12, 0 in cycle 13.
- Even lat=4 in cycle 0 (addr 3), then lat=3 in cycle 1 (addr 9) -> collision_even=1 in cycle 2; only addr 3 is written, in cycle 4.
- Simultaneous even addr=7 lat=2 and odd addr=7 lat=2 -> both enables high in the same cycle, waw_conflict=1 for that cycle.
- Odd entries lat=1 (addr 1) and lat=6 (addr 2) in flight; flush one cycle later -> addr 1 written, addr 2 never written, pending_mask all 0 afterwards.
- Offer with lat=0 and lat=7 -> lat=0 raises a lat_err pulse with no write; lat=7 writes 7 cycles later.
- Fill all 7 even slots, assert reset -> all outputs 0 next cycle, no writes ever emerge, pending_mask=0.
